// File: rtl/mod_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mod_updown_counter                                               |
// | Brief   : Up/down modulo counter with load, terminal count, wrap pulse     |
// |           and sticky overflow flag; wrap or saturate at the boundary.      |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module mod_updown_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             m,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] c_max_val = MAX_VAL;
  localparam logic [WIDTH-1:0] c_zero    = '0;
  localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_tc;
  logic             w_event;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_count_nxt;

  assign w_tc           = m ? (r_count == c_max_val) : (r_count == c_zero);
  assign w_event        = en & ~load & w_tc;
  assign w_load_clamped = (load_val > c_max_val) ? c_max_val : load_val;

  // Increment/decrement only happen off the boundary, so the WIDTH-bit
  // arithmetic never overflows even when MAX_VAL is all ones.
  always_comb begin
    w_count_nxt = r_count;
    if (load) begin
      w_count_nxt = w_load_clamped;
    end else if (en) begin
      if (w_tc) begin
        if (SATURATE == 1'b0) begin
          w_count_nxt = m ? c_zero : c_max_val;
        end
      end else if (m) begin
        w_count_nxt = r_count + c_one;
      end else begin
        w_count_nxt = r_count - c_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= c_zero;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_event;
      // A boundary event beats a simultaneous clear.
      r_ovf   <= w_event | (r_ovf & ~clr_ovf);
    end
  end

  assign count = r_count;
  assign tc    = w_tc;
  assign wrap  = r_wrap;
  assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mod_updown_counter                                            |
// | Brief   : Directed + random bench for three counter configurations.        |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, m, load, clr_ovf;
  logic [7:0] load_val;

  logic [7:0] cnt0, cnt1;
  logic [3:0] cnt2;
  logic       tc0, tc1, tc2, wr0, wr1, wr2, ov0, ov1, ov2;

  int errors = 0;
  int checks = 0;

  // Reference model state, one entry per configuration.
  int mc[3];
  int mw[3];
  int mo[3];
  int maxv[3] = '{9, 9, 15};
  int satv[3] = '{0, 1, 0};
  int mskv[3] = '{255, 255, 15};

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .SATURATE(1'b0)) u_wrap9 (
    .clk(clk), .rst(rst), .en(en), .m(m), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(cnt0), .tc(tc0), .wrap(wr0), .ovf(ov0));

  mod_updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .SATURATE(1'b1)) u_sat9 (
    .clk(clk), .rst(rst), .en(en), .m(m), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(cnt1), .tc(tc1), .wrap(wr1), .ovf(ov1));

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1'b0)) u_wrap15 (
    .clk(clk), .rst(rst), .en(en), .m(m), .load(load), .load_val(load_val[3:0]),
    .clr_ovf(clr_ovf), .count(cnt2), .tc(tc2), .wrap(wr2), .ovf(ov2));

  task automatic chk(input string tag, input int k, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d at %0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int c, t, w, o;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin c = int'(cnt0); t = int'(tc0); w = int'(wr0); o = int'(ov0); end
        1:       begin c = int'(cnt1); t = int'(tc1); w = int'(wr1); o = int'(ov1); end
        default: begin c = int'(cnt2); t = int'(tc2); w = int'(wr2); o = int'(ov2); end
      endcase
      chk("count", k, c, mc[k]);
      chk("wrap",  k, w, mw[k]);
      chk("ovf",   k, o, mo[k]);
      chk("tc",    k, t, (m ? (mc[k] == maxv[k]) : (mc[k] == 0)) ? 1 : 0);
    end
  endtask

  // Model of one rising edge, using the inputs currently applied.
  task automatic model_edge();
    int  v, step;
    bit  at_bound;
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        mc[k] = 0; mw[k] = 0; mo[k] = 0;
      end else if (load) begin
        v     = int'(load_val) & mskv[k];
        mc[k] = (v > maxv[k]) ? maxv[k] : v;
        mw[k] = 0;
        if (clr_ovf) mo[k] = 0;
      end else if (en) begin
        at_bound = m ? (mc[k] == maxv[k]) : (mc[k] == 0);
        step     = m ? 1 : -1;
        if (satv[k] != 0) begin
          if (!at_bound) mc[k] = mc[k] + step;
        end else begin
          mc[k] = (mc[k] + step + maxv[k] + 1) % (maxv[k] + 1);
        end
        mw[k] = at_bound ? 1 : 0;
        if (at_bound) mo[k] = 1;
        else if (clr_ovf) mo[k] = 0;
      end else begin
        mw[k] = 0;
        if (clr_ovf) mo[k] = 0;
      end
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit mm, input bit ld,
                       input int lv, input bit cl);
    rst = r; en = e; m = mm; load = ld; load_val = lv[7:0]; clr_ovf = cl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic cycle(input bit r, input bit e, input bit mm, input bit ld,
                       input int lv, input bit cl);
    drive(r, e, mm, ld, lv, cl);
    tick();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin mc[k] = 0; mw[k] = 0; mo[k] = 0; end
    drive(0, 1, 1, 1, 7, 0);
    @(negedge clk);
    // Reset state, regardless of en/load.
    tick();

    // Count up from 0 for 12 clocks: wrap after 9 for the mod-10 counter.
    for (int i = 0; i < 12; i++) cycle(1, 1, 1, 0, 0, 0);

    // Saturating count down from 2.
    cycle(1, 0, 0, 1, 2, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 0);

    // Load above MAX_VAL with en set, then wrap upward.
    cycle(1, 1, 1, 1, 200, 0);
    cycle(1, 1, 1, 0, 0, 0);

    // Event coinciding with clear keeps ovf; clear alone drops it.
    cycle(1, 0, 1, 1, 9, 0);
    cycle(1, 1, 1, 0, 0, 1);
    cycle(1, 0, 1, 0, 0, 1);

    // Reset mid-count; rst changes between edges must do nothing.
    cycle(1, 0, 1, 1, 5, 0);
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 0);
    #2 check_all();
    tick();
    drive(1, 0, 1, 0, 0, 0);
    #2 check_all();
    tick();

    // Down from 0 wraps to MAX_VAL, then up from MAX_VAL wraps to 0.
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 25) != 0, ($urandom % 4) != 0, $urandom % 2,
            ($urandom % 8) == 0, int'($urandom % 256), ($urandom % 8) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1: terminal value; the count range is 0..MAX_VAL, and MAX_VAL must not exceed 2**WIDTH-1.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at the boundary, 1 = hold at the boundary.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port m, input, 1 bit: direction; 1 = up, 0 = down.
REQ-008 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 SHALL have port load_val, input, WIDTH bits: value to load.
REQ-010 SHALL have port clr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-011 SHALL have port count, output, WIDTH bits: registered count value.
REQ-012 SHALL have port tc, output, 1 bit: combinational terminal count, high when (m=1 and count=MAX_VAL) or (m=0 and count=0).
REQ-013 SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking a boundary event.
REQ-014 SHALL have port ovf, output, 1 bit: registered sticky boundary-event flag.

Function
REQ-015 SHALL apply update priority per rising clk edge: rst low, then load, then en, then hold.
REQ-016 When load=1, count SHALL take load_val, or MAX_VAL if load_val > MAX_VAL (clamp); wrap SHALL be 0 that cycle; ovf SHALL be unaffected by the load itself.
REQ-017 When en=1, load=0, m=1 and count<MAX_VAL, count SHALL increment by 1.
REQ-018 When en=1, load=0, m=0 and count>0, count SHALL decrement by 1.
REQ-019 A boundary event SHALL be en=1, load=0 and tc=1 at the clock edge.
REQ-020 On a boundary event with SATURATE=0, count SHALL go to 0 (up) or MAX_VAL (down).
REQ-021 On a boundary event with SATURATE=1, count SHALL hold its value.
REQ-022 wrap SHALL be 1 in the cycle following a boundary event and 0 otherwise, in both modes; back-to-back events give continuous wrap=1.
REQ-023 ovf SHALL be set by a boundary event and held until cleared by clr_ovf=1 or reset.
REQ-024 On a boundary event coinciding with clr_ovf=1, set SHALL win and ovf SHALL be 1.
REQ-025 A change of m while en=1 SHALL take effect on the next edge with no dead cycle; tc SHALL follow m combinationally.
REQ-026 When en=0 and load=0, count SHALL hold; wrap SHALL be 0; ovf SHALL hold.
REQ-027 No intermediate arithmetic SHALL exceed WIDTH+1 bits, and count SHALL never exceed MAX_VAL, including MAX_VAL=2**WIDTH-1 where natural overflow coincides with wrap.
REQ-028 Latency SHALL be one clock from en/load to count, and one clock from the boundary event to wrap and ovf.

Reset
REQ-029 When rst=0 at a rising clk edge, count, wrap and ovf SHALL all become 0, regardless of en, load and clr_ovf.
REQ-030 A reset asserted mid-count SHALL take effect at the next edge and discard any pending load or boundary event.
REQ-031 Counting SHALL resume on the first edge with rst=1.
REQ-032 rst SHALL have no asynchronous effect between clock edges.

Verification (WIDTH=8, MAX_VAL=9 unless stated)
REQ-033 SHALL cover: SATURATE=0, m=1, en=1 from 0 for 12 clocks -> count 1..9,0,1,2; wrap high exactly one cycle after count=9 was left; ovf=1 thereafter.
REQ-034 SHALL cover: SATURATE=1, m=0, en=1 from 2 for 4 clocks -> count 1,0,0,0; wrap=1 on each cycle after an edge with count=0; tc=1 while count=0.
REQ-035 SHALL cover: load=1, load_val=200, en=1 same cycle -> count=9, wrap=0; next edge with m=1, en=1 -> count=0, wrap=1.
REQ-036 SHALL cover: ovf=1, boundary event and clr_ovf=1 in the same cycle -> ovf stays 1; next cycle clr_ovf=1 with no event -> ovf=0.
REQ-037 SHALL cover: count=5, en=1, rst=0 for one edge -> count=0, wrap=0, ovf=0; rst deasserted between edges causes no change until the next edge.
REQ-038 SHALL cover: WIDTH=4, MAX_VAL=15, SATURATE=0, m=0 from 0 -> count 15, wrap=1; m=1 from 15 -> count 0.
